// File: rtl/perf_stat_pkg.sv
// Shared constants for perf_stat_display: 7-segment glyphs, blank code, run/halt state type.
`timescale 1ns/1ps
package perf_stat_pkg;

    // Segment pattern with every segment and the decimal point dark (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Hex glyphs, active-low {dp, g, f, e, d, c, b, a}; entry 15 first, dp kept off.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    // Map one hex nibble to its active-low segment pattern.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_GLYPH[nib];
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed hex display scanner: one digit lit at a time, advancing every 2^SCAN_LOG cycles.
`timescale 1ns/1ps
module seg7_scan
    import perf_stat_pkg::*;
#(
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned SCAN_LOG = 10
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [NUM_DIG*4-1:0]   value,
    output logic [NUM_DIG-1:0]     AN,
    output logic [7:0]             Segment
);

    localparam int unsigned DIG_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [SCAN_LOG-1:0] scan_cnt;
    logic [DIG_W-1:0]    digit;
    logic [3:0]          nib;

    // Pick the nibble belonging to the digit currently being driven.
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            if (digit == DIG_W'(k)) begin
                nib = value[k*4 +: 4];
            end
        end
    end

    // Scan timer, digit index and registered anode/segment drive.
    always_ff @(posedge clk) begin
        if (RST) begin
            scan_cnt <= '0;
            digit    <= '0;
            AN       <= '1;
            Segment  <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + SCAN_LOG'(1);
            if (&scan_cnt) begin
                digit <= (digit == DIG_W'(NUM_DIG - 1)) ? '0 : digit + DIG_W'(1);
            end
            AN      <= ~(NUM_DIG'(1) << digit);
            Segment <= hex_to_seg(nib);
        end
    end

endmodule

// File: rtl/perf_stat_display.sv
// Event counters with run/halt clock-enable generation and a scanned hex display of one channel.
// Build option: define PERF_SAT_EN to make counters saturate instead of wrapping.
`timescale 1ns/1ps
module perf_stat_display
    import perf_stat_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned SCAN_LOG = 10,
    parameter int unsigned SLOW_LOG = 20,
    parameter int unsigned SEL_W    = 3
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               stop_button,
    input  logic               Fre_Choice,
    input  logic [SEL_W-1:0]   select,
    input  logic [NUM_CH-1:0]  evt_inc,
    output logic               cpu_en,
    output logic               halted,
    output logic [7:0]         LED,
    output logic [7:0]         Segment,
    output logic [NUM_DIG-1:0] AN
);

    localparam int unsigned DISP_W = NUM_DIG * 4;

    run_state_t          state;
    run_state_t          state_next;
    logic                btn_prev;
    logic [SLOW_LOG-1:0] presc;
    logic                presc_wrap;
    logic [CNT_W-1:0]    cnt [NUM_CH];
    logic [CNT_W-1:0]    sel_val;
    logic [DISP_W-1:0]   disp_val;

    // Run/halt state and button edge-detect register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= ST_RUN;
            btn_prev <= 1'b0;
        end else begin
            state    <= state_next;
            btn_prev <= stop_button;
        end
    end

    // Toggle run/halt on a rising edge of the button only.
    always_comb begin
        state_next = state;
        if (stop_button && !btn_prev) begin
            state_next = (state == ST_RUN) ? ST_HALT : ST_RUN;
        end
    end

    assign halted     = (state == ST_HALT);
    assign presc_wrap = &presc;

    // Free-running prescaler and registered datapath clock-enable.
    always_ff @(posedge clk) begin
        if (RST) begin
            presc  <= '0;
            cpu_en <= 1'b0;
        end else begin
            presc  <= presc + SLOW_LOG'(1);
            cpu_en <= Fre_Choice ? (presc_wrap && !halted) : !halted;
        end
    end

    // Per-channel event counters, qualified by cpu_en.
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (evt_inc[i] && cpu_en) begin
`ifdef PERF_SAT_EN
                    if (cnt[i] != '1) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
`else
                    cnt[i] <= cnt[i] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Channel select; out-of-range selects read as zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (select == SEL_W'(i)) begin
                sel_val = cnt[i];
            end
        end
    end

    // Registered LED and display value of the selected channel.
    always_ff @(posedge clk) begin
        if (RST) begin
            LED      <= 8'h00;
            disp_val <= '0;
        end else begin
            LED      <= 8'(sel_val);
            disp_val <= DISP_W'(sel_val);
        end
    end

    seg7_scan #(
        .NUM_DIG  (NUM_DIG),
        .SCAN_LOG (SCAN_LOG)
    ) u_scan (
        .clk     (clk),
        .RST     (RST),
        .value   (disp_val),
        .AN      (AN),
        .Segment (Segment)
    );

endmodule

// File: tb/tb_perf_stat_display.sv
// Directed bench for perf_stat_display: a 16-bit build and an 8-bit build share all stimulus.
`timescale 1ns/1ps
module tb_perf_stat_display;

    logic       clk = 1'b0;
    logic       RST;
    logic       stop_button;
    logic       Fre_Choice;
    logic [2:0] select;
    logic [3:0] evt_inc;

    logic       cpu_en,  cpu_en8;
    logic       halted,  halted8;
    logic [7:0] LED,     LED8;
    logic [7:0] Segment, Segment8;
    logic [3:0] AN,      AN8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perf_stat_display #(
        .NUM_CH(4), .CNT_W(16), .NUM_DIG(4), .SCAN_LOG(2), .SLOW_LOG(4), .SEL_W(3)
    ) dut (
        .clk(clk), .RST(RST), .stop_button(stop_button), .Fre_Choice(Fre_Choice),
        .select(select), .evt_inc(evt_inc), .cpu_en(cpu_en), .halted(halted),
        .LED(LED), .Segment(Segment), .AN(AN)
    );

    perf_stat_display #(
        .NUM_CH(4), .CNT_W(8), .NUM_DIG(4), .SCAN_LOG(2), .SLOW_LOG(4), .SEL_W(3)
    ) dut8 (
        .clk(clk), .RST(RST), .stop_button(stop_button), .Fre_Choice(Fre_Choice),
        .select(select), .evt_inc(evt_inc), .cpu_en(cpu_en8), .halted(halted8),
        .LED(LED8), .Segment(Segment8), .AN(AN8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] an_exp  [4];
        logic [7:0] seg_exp [4];
        logic [3:0] an_prev;
        int         pulses;
        int         last;
        int         first;
        int         found;
        int         guard;

        an_exp[0]  = 4'b1110; an_exp[1]  = 4'b1101; an_exp[2]  = 4'b1011; an_exp[3]  = 4'b0111;
        seg_exp[0] = 8'h8E;   seg_exp[1] = 8'hA4;   seg_exp[2] = 8'h88;   seg_exp[3] = 8'hF9;

        RST = 1'b1; stop_button = 1'b0; Fre_Choice = 1'b0; select = 3'd0; evt_inc = 4'b0000;
        tick(2);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_led", LED, 8'h00);
        chk("rst_seg", Segment, 8'hFF);
        chk("rst_an", AN, 4'hF);
        chk("rst_halted", halted, 0);

        // Fast mode counting on channel 0
        RST = 1'b0;
        tick(1);
        evt_inc = 4'b0001;
        tick(5);
        evt_inc = 4'b0000;
        tick(2);
        chk("fast_led0", LED, 8'h05);
        chk("fast_halted", halted, 0);
        chk("fast_cpu_en", cpu_en, 1);
        for (int c = 1; c < 4; c++) begin
            select = 3'(c);
            tick(2);
            chk("fast_other", LED, 8'h00);
        end
        select = 3'd0;

        // Run/halt toggle
        stop_button = 1'b1;
        tick(1);
        chk("halt_set", halted, 1);
        tick(1);
        chk("halt_cpu_en", cpu_en, 0);
        evt_inc = 4'b0001;
        tick(8);
        chk("halt_held", halted, 1);
        chk("halt_cpu_en_held", cpu_en, 0);
        evt_inc = 4'b0000;
        tick(2);
        chk("halt_no_count", LED, 8'h05);
        stop_button = 1'b0;
        tick(1);
        stop_button = 1'b1;
        tick(1);
        chk("resume", halted, 0);
        tick(1);
        chk("resume_cpu_en", cpu_en, 1);
        stop_button = 1'b0;

        // Slow mode from a fresh reset: prescaler phase is known
        RST = 1'b1; Fre_Choice = 1'b1;
        tick(1);
        RST = 1'b0; evt_inc = 4'b0010;
        pulses = 0; last = -1; first = -1;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (cpu_en) begin
                pulses++;
                if (last >= 0) chk("slow_spacing", 32'(i - last), 16);
                else first = i;
                last = i;
            end
        end
        tick(1);
        evt_inc = 4'b0000;
        chk("slow_pulses", 32'(pulses), 4);
        chk("slow_first", 32'(first), 15);
        select = 3'd1;
        tick(2);
        chk("slow_cnt1", LED, 8'h04);

        // Overflow on channel 2: 300 events
        Fre_Choice = 1'b0; select = 3'd2;
        tick(1);
        evt_inc = 4'b0100;
        tick(300);
        evt_inc = 4'b0000;
        tick(2);
        chk("ovf_w16", LED, 8'h2C);
`ifdef PERF_SAT_EN
        chk("ovf_w8", LED8, 8'hFF);
`else
        chk("ovf_w8", LED8, 8'h2C);
`endif

        // Counter 3 to 16'h1A2F, then scan the display
        select = 3'd3;
        evt_inc = 4'b1000;
        tick(16'h1A2F);
        evt_inc = 4'b0000;
        tick(2);
        chk("disp_led", LED, 8'h2F);
        found = 0; guard = 0; an_prev = AN;
        while (!found && guard < 40) begin
            tick(1);
            guard++;
            if (AN == 4'b1110 && an_prev != 4'b1110) found = 1;
            an_prev = AN;
        end
        chk("scan_sync", 32'(found), 1);
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                chk("scan_an", AN, an_exp[d]);
                chk("scan_seg", Segment, seg_exp[d]);
                tick(1);
            end
        end
        chk("scan_wrap", AN, 4'b1110);

        // Out-of-range select shows zero
        select = 3'd5;
        tick(2);
        chk("sel5_led", LED, 8'h00);
        tick(2);
        for (int r = 0; r < 4; r++) begin
            chk("sel5_seg", Segment, 8'hC0);
            tick(4);
        end

        // Reset wins over a button edge and events in the same cycle
        stop_button = 1'b1; evt_inc = 4'b1111; RST = 1'b1;
        tick(1);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_an", AN, 4'hF);
        chk("mid_rst_seg", Segment, 8'hFF);
        chk("mid_rst_cpu_en", cpu_en, 0);
        RST = 1'b0; stop_button = 1'b0; evt_inc = 4'b0000;
        tick(2);
        chk("mid_rst_run", halted, 0);
        for (int c = 0; c < 4; c++) begin
            select = 3'(c);
            tick(2);
            chk("mid_rst_cnt", LED, 8'h00);
            chk("mid_rst_cnt8", LED8, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perf_stat_display.md
Name: perf_stat_display

Overview:
- Parametrised successor to the branch-statistics datapath display.
- Counts NUM_CH event channels.
- Generates the datapath run clock-enable with run/halt and fast/slow selection.
- Scans the selected counter onto a multiplexed hex 7-segment display plus LEDs.
- Sits between the CPU datapath (event pulses in, cpu_en out) and the board I/O.

Parameters:
- NUM_CH, 4, number of event counters (1..8)
- CNT_W, 16, counter width in bits (requires NUM_DIG*4 >= CNT_W)
- NUM_DIG, 4, number of 7-segment digits scanned
- SCAN_LOG, 10, digit advances every 2^SCAN_LOG cycles
- SLOW_LOG, 20, slow mode: cpu_en pulses once every 2^SLOW_LOG cycles
- SEL_W, 3, width of select (2^SEL_W >= NUM_CH)

Ports:
- clk  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- stop_button  in  1  run/halt toggle, level input, already synchronised
- Fre_Choice  in  1  0 = fast (every cycle), 1 = slow (prescaled)
- select  in  SEL_W  channel shown on display/LED
- evt_inc  in  NUM_CH  per-channel event pulse, one increment per qualified cycle
- cpu_en  out  1  datapath clock-enable
- halted  out  1  1 while halted
- LED  out  8  low 8 bits of selected counter
- Segment  out  8  [6:0] = gfedcba, [7] = dp; all active-low
- AN  out  NUM_DIG  digit enables, active-low, one-hot-zero

Behaviour:
- Reset
  - Clock is clk; reset is RST, synchronous, active-high.
  - RST=1 at an edge clears counters, prescaler, scan counter and halted, and the edge-detect register.
  - Reset values: cpu_en=0, LED=0, Segment=8'hFF, AN=all 1.
  - RST has priority over every simultaneous event, including a mid-scan digit or a button edge.
- Run/halt
  - A rising edge of stop_button (registered previous value 0, current 1) toggles halted.
  - A held level causes no further toggles.
- Clock-enable
  - cpu_en is registered.
  - Fast mode: cpu_en=!halted every cycle.
  - Slow mode: a free-running SLOW_LOG-bit prescaler wraps; cpu_en=1 for exactly one cycle at wrap if !halted.
  - Prescaler keeps running while halted.
  - Changing Fre_Choice takes effect the next cycle, without prescaler reset.
- Counting
  - Channel i increments when evt_inc[i] && cpu_en.
  - New value is visible on the following edge (1-cycle latency).
  - Channels are independent; simultaneous increments on all channels are all counted.
  - At max value (2^CNT_W-1), behaviour is per the Optional Feature.
- Display
  - Digit index d advances 0..NUM_DIG-1 every 2^SCAN_LOG cycles and wraps to 0.
  - Segment and AN are registered: AN[d]=0, others 1.
  - Segment shows the hex glyph of nibble d of counter[select], computed from values of the previous cycle.
  - Nibbles above CNT_W read 0.
  - dp is always 1 (off).
- Select handling
  - select >= NUM_CH displays value 0 and LED=0.
  - select changes are reflected on the next registered update (1-cycle latency).

Optional Feature:
- Macro PERF_SAT_EN.
  - Defined: counters saturate at 2^CNT_W-1; further events are ignored.
  - Undefined: counters wrap to 0 modulo 2^CNT_W.

Decomposition:
- Package perf_stat_pkg:
  - 16-entry hex-to-7-segment glyph constant (active-low gfedcba)
  - SEG_BLANK = 8'hFF
  - hex_to_seg function
- One natural sub-module, seg7_scan.
  - It owns the scan counter, digit index, AN and Segment registers.
  - It takes a NUM_DIG*4-bit value input.
- The top holds the counters, select mux, run/halt and prescaler.

Test Plan:
- Reset, Fast, count: RST=1 for 2 cycles; Fre_Choice=0, evt_inc=4'b0001 for 5 cycles -> counter0=5, LED=8'h05, halted=0, cpu_en=1; other counters 0.
- Run/halt toggle: stop_button pulse 0->1, held 10 cycles -> halted=1 and cpu_en=0 from the 2nd edge; evt_inc held 1 adds nothing. Second pulse -> halted=0.
- Slow mode, SLOW_LOG=4: Fre_Choice=1, evt_inc=4'b0010 held 64 cycles -> cpu_en pulses exactly 4 times, 16 cycles apart; counter1=4.
- Overflow, CNT_W=8: 300 events on channel 2 -> 255 with PERF_SAT_EN defined, 44 (300 mod 256) without.
- Display scan, SCAN_LOG=2: counter3=16'h1A2F, select=3 -> AN cycles 1110, 1101, 1011, 0111, each held 4 cycles, then wraps. Segment glyphs are F, 2, A, 1, i.e. 8'h8E, 8'hA4, 8'h88, 8'hF9. select=5 -> glyph 0 (8'hC0), LED=0.
- Reset mid-operation: RST asserted with stop_button rising and evt_inc all 1 in the same cycle -> all counters 0, halted=0, AN all 1, Segment=8'hFF next cycle.
